// File: rtl/jam_cost_table.sv
// jam_cost_table: 8x8 worker-by-job cost table for the job-assignment search
// engine. The table is loaded serially, then answers W/J lookups
// combinationally. The block also captures the engine's result and counts
// the lookups the search consumed.
module jam_cost_table #(
   parameter int unsigned COST_W = 7,
   parameter int unsigned ACC_W  = 19
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CLR,
   input  logic              LD_VALID,
   input  logic [COST_W-1:0] LD_DATA,
   output logic              LD_READY,
   output logic              TABLE_READY,
   input  logic [2:0]        W,
   input  logic [2:0]        J,
   output logic [COST_W-1:0] Cost,
   input  logic              JAM_VALID,
   input  logic [9:0]        MIN_IN,
   input  logic [3:0]        CNT_IN,
   output logic              DONE,
   output logic [9:0]        RESULT_MIN,
   output logic [3:0]        RESULT_CNT,
   output logic [ACC_W-1:0]  ACCESS_CNT
);

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SERVE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [5:0]        ptr_q, ptr_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [9:0]        rmin_q, rmin_d;
   logic [3:0]        rcnt_q, rcnt_d;
   logic              wr_en;
   logic [COST_W-1:0] cost_mem_q [64];

   // Next-state, pointer, counter and capture logic; CLR overrides everything
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      acc_d   = acc_q;
      rmin_d  = rmin_q;
      rcnt_d  = rcnt_q;
      wr_en   = 1'b0;
      if (CLR) begin
         state_d = ST_LOAD;
         ptr_d   = '0;
         acc_d   = '0;
         rmin_d  = '0;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (LD_VALID) begin
                  wr_en = 1'b1;
                  ptr_d = ptr_q + 6'd1;
                  if (ptr_q == 6'd63) begin
                     state_d = ST_SERVE;
                  end
               end
            end
            ST_SERVE: begin
               if (JAM_VALID) begin
                  rmin_d  = MIN_IN;
                  rcnt_d  = CNT_IN;
                  state_d = ST_DONE;
               end else if (acc_q != '1) begin
                  acc_d = acc_q + ACC_W'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_LOAD;
            end
         endcase
      end
   end

   // Control state and captures, asynchronously reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_LOAD;
         ptr_q   <= '0;
         acc_q   <= '0;
         rmin_q  <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         acc_q   <= acc_d;
         rmin_q  <= rmin_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // Cost storage; not reset, validity is tracked by the state machine
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         cost_mem_q[ptr_q] <= LD_DATA;
      end
   end

   // Outputs; Cost is gated so unloaded storage never reaches the engine
   always_comb begin
      LD_READY    = (state_q == ST_LOAD);
      TABLE_READY = (state_q == ST_SERVE) || (state_q == ST_DONE);
      DONE        = (state_q == ST_DONE);
      Cost        = TABLE_READY ? cost_mem_q[{W, J}] : '0;
      RESULT_MIN  = rmin_q;
      RESULT_CNT  = rcnt_q;
      ACCESS_CNT  = acc_q;
   end

endmodule
